multiword_sub_ctrl: RTL

- Sequences one N-bit ripple subtract slice (a + ~b + carry) over WORDS words. Together they form a multi-precision subtractor of width N*WORDS.
- Processes one word per clock, LSW first. The carry is registered between words.
- Registered result and flags (borrow, zero, signed overflow) are presented to the consuming datapath with a start/done handshake.

---
 rtl/multiword_sub_ctrl.sv | 93 +++++++++
 1 files changed

// File: rtl/multiword_sub_ctrl.sv
// Multi-precision subtractor: one N-bit subtract slice stepped over WORDS words, LSW first.
// The inter-word carry is registered; results and flags are valid on the one-cycle done pulse.
module multiword_sub_ctrl #(
   parameter int N     = 32,
   parameter int WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [N*WORDS-1:0]   a,
   input  logic [N*WORDS-1:0]   b,
   output logic                 busy,
   output logic                 done,
   output logic [N*WORDS-1:0]   diff,
   output logic                 borrow,
   output logic                 zero,
   output logic                 overflow
);

   localparam int W    = N * WORDS;
   localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]      state;
   logic [IDXW-1:0] idx;
   logic            carry;
   logic [W-1:0]    a_r;
   logic [W-1:0]    b_r;

   logic [N-1:0]    a_word;
   logic [N-1:0]    b_word;
   logic [N:0]      sum;
   logic [W-1:0]    diff_next;
   logic            last;

   // Handshake: start is sampled only in IDLE; done pulses for one cycle after the last word.
   always_comb begin
      a_word    = a_r[idx*N +: N];
      b_word    = b_r[idx*N +: N];
      sum       = {1'b0, a_word} + {1'b0, ~b_word} + {{N{1'b0}}, carry};
      diff_next = diff;
      diff_next[idx*N +: N] = sum[N-1:0];
      last      = (idx == IDXW'(WORDS - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         idx      <= '0;
         carry    <= 1'b1;
         a_r      <= '0;
         b_r      <= '0;
         diff     <= '0;
         borrow   <= 1'b0;
         zero     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_r   <= a;
                  b_r   <= b;
                  idx   <= '0;
                  carry <= 1'b1;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               diff  <= diff_next;
               carry <= sum[N];
               if (last) begin
                  // Flags see the complete result, including the slice written this cycle.
                  borrow   <= ~sum[N];
                  zero     <= (diff_next == '0);
                  overflow <= (a_r[W-1] != b_r[W-1]) && (sum[N-1] != a_r[W-1]);
                  state    <= ST_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);

endmodule
